// File: rtl/hirose_present_stream_ctrl.sv
// -----------------------------------------------------------------------------
// hirose_present_stream_ctrl
//
// Streaming sequencer for one hirose_present compression core. It accepts a
// message as 16-bit blocks over a valid/ready handshake and keeps the 128-bit
// chaining state {H_left, H_right}. For every block it runs the core once:
// a one-cycle start pulse, a wait for the core to finish, then a chain update.
// The final chaining value is presented as the digest on a valid/ready output.
//
// Optional feature (macro HIROSE_CTRL_LEN_PAD_EN):
//   When defined, one extra compression runs after the last message block.
//   Its plaintext is the message block count (mod 2^CNT_W, low 16 bits).
//   When undefined, the pad logic is absent and DONE follows the last
//   block's chain update directly.
//
// Parameters:
//   IV_LEFT / IV_RIGHT : initial chaining halves, reloaded after each digest
//   C_CONST            : Hirose constant c driven to the core
//   CNT_W              : block counter width (wraps modulo 2^CNT_W)
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready : message block input handshake
//   digest/digest_valid/digest_ready : final hash output handshake
//   core_rst           : one-cycle start pulse to the core
//   core_c             : constant c
//   core_plaintext     : block under compression, stable START..UPDATE
//   core_prev_left/right : current chaining halves
//   core_end_hash      : core done (level, cleared by core_rst)
//   core_hash_o        : core result {left, right}
//   busy               : high in every state except IDLE and DONE
//
// All handshake/status outputs are registered; their next values are derived
// from the next state so they line up with the state they describe.
// -----------------------------------------------------------------------------
module hirose_present_stream_ctrl #(
  parameter logic [63:0] IV_LEFT  = 64'h0,
  parameter logic [63:0] IV_RIGHT = 64'h0,
  parameter logic [63:0] C_CONST  = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    s_data,
  input  logic           s_valid,
  input  logic           s_last,
  output logic           s_ready,
  output logic [127:0]   digest,
  output logic           digest_valid,
  input  logic           digest_ready,
  output logic           core_rst,
  output logic [63:0]    core_c,
  output logic [15:0]    core_plaintext,
  output logic [63:0]    core_prev_left,
  output logic [63:0]    core_prev_right,
  input  logic           core_end_hash,
  input  logic [127:0]   core_hash_o,
  output logic           busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_ACCEPT = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        h_left_q, h_left_d;
  logic [63:0]        h_right_q, h_right_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        pt_q, pt_d;
  logic               last_q, last_d;
  logic               s_ready_q, s_ready_d;
  logic               digest_valid_q, digest_valid_d;
  logic               core_rst_q, core_rst_d;
  logic               busy_q, busy_d;
`ifdef HIROSE_CTRL_LEN_PAD_EN
  logic               pad_done_q, pad_done_d;

  // Low 16 bits of the block count, zero-extended when CNT_W < 16.
  function automatic logic [15:0] pad_block(input logic [CNT_W-1:0] cnt);
    logic [CNT_W+15:0] ext;
    ext = {{16{1'b0}}, cnt};
    return ext[15:0];
  endfunction
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    h_left_d  = h_left_q;
    h_right_d = h_right_q;
    cnt_d     = cnt_q;
    pt_d      = pt_q;
    last_d    = last_q;
`ifdef HIROSE_CTRL_LEN_PAD_EN
    pad_done_d = pad_done_q;
`endif

    case (state_q)
      ST_IDLE, ST_ACCEPT: begin
        // The first accepted block in IDLE starts a new message.
        if (s_valid) begin
          pt_d    = s_data;
          last_d  = s_last;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_START;
        end else begin
          state_d = state_q;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The core may already report completion on the first WAIT cycle.
        if (core_end_hash) begin
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_UPDATE: begin
        h_left_d  = core_hash_o[127:64];
        h_right_d = core_hash_o[63:0];
        if (!last_q) begin
          state_d = ST_ACCEPT;
        end else begin
`ifdef HIROSE_CTRL_LEN_PAD_EN
          // last_flag stays set, so the pad block's UPDATE ends in DONE.
          if (!pad_done_q) begin
            pt_d       = pad_block(cnt_q);
            pad_done_d = 1'b1;
            state_d    = ST_START;
          end else begin
            state_d = ST_DONE;
          end
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        // Digest is held until taken; then chaining restarts from the IV.
        if (digest_ready) begin
          h_left_d  = IV_LEFT;
          h_right_d = IV_RIGHT;
          cnt_d     = '0;
`ifdef HIROSE_CTRL_LEN_PAD_EN
          pad_done_d = 1'b0;
`endif
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_ready_d      = (state_d == ST_IDLE) || (state_d == ST_ACCEPT);
    digest_valid_d = (state_d == ST_DONE);
    core_rst_d     = (state_d == ST_START);
    busy_d         = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  // State, chaining and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      h_left_q       <= IV_LEFT;
      h_right_q      <= IV_RIGHT;
      cnt_q          <= '0;
      pt_q           <= 16'h0;
      last_q         <= 1'b0;
      s_ready_q      <= 1'b1;
      digest_valid_q <= 1'b0;
      core_rst_q     <= 1'b0;
      busy_q         <= 1'b0;
`ifdef HIROSE_CTRL_LEN_PAD_EN
      pad_done_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      h_left_q       <= h_left_d;
      h_right_q      <= h_right_d;
      cnt_q          <= cnt_d;
      pt_q           <= pt_d;
      last_q         <= last_d;
      s_ready_q      <= s_ready_d;
      digest_valid_q <= digest_valid_d;
      core_rst_q     <= core_rst_d;
      busy_q         <= busy_d;
`ifdef HIROSE_CTRL_LEN_PAD_EN
      pad_done_q     <= pad_done_d;
`endif
    end
  end

  assign s_ready         = s_ready_q;
  assign digest_valid    = digest_valid_q;
  assign digest          = {h_left_q, h_right_q};
  assign core_rst        = core_rst_q;
  assign core_c          = C_CONST;
  assign core_plaintext  = pt_q;
  assign core_prev_left  = h_left_q;
  assign core_prev_right = h_right_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_hirose_present_stream_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for hirose_present_stream_ctrl with a behavioural core stub.
// Stub: end_hash rises stub_lat cycles after the start pulse (0 = already high
// on the first WAIT cycle); hash_o = {prev_left ^ pt, prev_right + pt}.
// Expected digests come from a message-level model: fold every block (and the
// optional count block) into {left, right} starting from IV = 0.
// -----------------------------------------------------------------------------
module tb_hirose_present_stream_ctrl;

  logic           clk = 1'b0;
  logic           rst;
  logic [15:0]    s_data;
  logic           s_valid;
  logic           s_last;
  logic           s_ready;
  logic [127:0]   digest;
  logic           digest_valid;
  logic           digest_ready;
  logic           core_rst;
  logic [63:0]    core_c;
  logic [15:0]    core_plaintext;
  logic [63:0]    core_prev_left;
  logic [63:0]    core_prev_right;
  logic           core_end_hash;
  logic [127:0]   core_hash_o;
  logic           busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  hirose_present_stream_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_last          (s_last),
    .s_ready         (s_ready),
    .digest          (digest),
    .digest_valid    (digest_valid),
    .digest_ready    (digest_ready),
    .core_rst        (core_rst),
    .core_c          (core_c),
    .core_plaintext  (core_plaintext),
    .core_prev_left  (core_prev_left),
    .core_prev_right (core_prev_right),
    .core_end_hash   (core_end_hash),
    .core_hash_o     (core_hash_o),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Core stub.
  int stub_lat = 5;
  int stub_cnt;
  always @(posedge clk) begin
    if (rst) begin
      core_end_hash <= 1'b0;
      stub_cnt      <= 0;
    end else if (core_rst) begin
      core_end_hash <= (stub_lat == 0);
      stub_cnt      <= stub_lat;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) core_end_hash <= 1'b1;
    end
  end
  assign core_hash_o = {core_prev_left ^ {48'h0, core_plaintext},
                        core_prev_right + {48'h0, core_plaintext}};

  // Protocol monitor: start-pulse count/width, plaintext stability and
  // s_ready low while a compression is in flight.
  int   pulses = 0, wide_pulses = 0, pt_changes = 0, sready_viol = 0;
  logic prev_rst_seen = 1'b0;
  logic in_comp = 1'b0;
  logic [15:0] pt_snap;
  always @(negedge clk) begin
    prev_rst_seen <= core_rst;
    if (core_rst) begin
      pulses <= pulses + 1;
      if (prev_rst_seen) wide_pulses <= wide_pulses + 1;
    end
    if (rst) begin
      in_comp <= 1'b0;
    end else if (core_rst) begin
      in_comp <= 1'b1;
      pt_snap <= core_plaintext;
      if (s_ready) sready_viol <= sready_viol + 1;
    end else if (in_comp) begin
      if (core_plaintext !== pt_snap) pt_changes <= pt_changes + 1;
      if (s_ready) sready_viol <= sready_viol + 1;
      if (core_end_hash) in_comp <= 1'b0;
    end
  end

  logic [15:0] msg [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Message-level reference: chain every block, then the optional count block.
  function automatic logic [127:0] model_digest();
    logic [63:0] l = 64'h0;
    logic [63:0] r = 64'h0;
    logic [15:0] n;
    foreach (msg[i]) begin
      l = l ^ {48'h0, msg[i]};
      r = r + {48'h0, msg[i]};
    end
`ifdef HIROSE_CTRL_LEN_PAD_EN
    n = 16'(msg.size());
    l = l ^ {48'h0, n};
    r = r + {48'h0, n};
`else
    n = 16'h0;
`endif
    return {l, r} | {112'h0, n & 16'h0};
  endfunction

  function automatic int pad_blocks();
`ifdef HIROSE_CTRL_LEN_PAD_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  // Called at a negedge; returns at the negedge after the block is taken.
  task automatic send_block(input logic [15:0] d, input logic last);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (s_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", 128'(t < 1000), 128'd1);
    @(negedge clk);
    check("start_after_accept", {126'h0, core_rst, busy}, 128'h3);
  endtask

  // Sends msg, waits for the digest, checks it, holds it for hold cycles and
  // takes it. gaps inserts random idle cycles between blocks.
  task automatic run_msg(input string tag, input bit gaps, input int hold);
    int p0 = pulses;
    int w0 = wide_pulses;
    int t  = 0;
    int bad = 0;
    logic [127:0] exp = model_digest();
    logic [127:0] snap;
    foreach (msg[i]) begin
      send_block(msg[i], (i == msg.size() - 1));
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 12)) @(negedge clk);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    while (digest_valid !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_digest_valid"}, {127'h0, digest_valid}, 128'h1);
    check({tag, "_digest"}, digest, exp);
    check({tag, "_pulses"}, 128'(pulses - p0), 128'(msg.size() + pad_blocks()));
    check({tag, "_wide_pulses"}, 128'(wide_pulses - w0), 128'd0);
    snap = digest;
    repeat (hold) begin
      @(negedge clk);
      if (digest !== snap || digest_valid !== 1'b1) bad++;
    end
    if (hold > 0) check({tag, "_hold_stable"}, 128'(bad), 128'd0);
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    check({tag, "_idle_after_take"}, {125'h0, s_ready, digest_valid, busy}, 128'h4);
    check({tag, "_iv_reload"}, {core_prev_left, core_prev_right}, 128'h0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 16'h0;
    s_last = 1'b0;
    digest_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {124'h0, s_ready, digest_valid, core_rst, busy}, 128'h8);
    check("reset_digest", digest, 128'h0);
    check("core_c", {64'h0, core_c}, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    rst = 1'b0;
    @(negedge clk);

    // digest_ready while no digest is pending is ignored.
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    check("ready_ignored", {126'h0, s_ready, digest_valid}, 128'h2);

    // Single block.
    msg = '{16'h1234};
`ifdef HIROSE_CTRL_LEN_PAD_EN
    check("single_const", model_digest(), {64'h1235, 64'h1235});
`else
    check("single_const", model_digest(), {64'h1234, 64'h1234});
`endif
    run_msg("single", 1'b0, 0);

    // Three blocks with gaps.
    msg = '{16'h1, 16'h2, 16'h3};
    run_msg("three", 1'b1, 0);
`ifdef HIROSE_CTRL_LEN_PAD_EN
    check("three_const", {core_prev_left, core_prev_right} | 128'h0, 128'h0);
`endif

    // Back-to-back blocks with s_valid held high.
    msg = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    run_msg("queued", 1'b0, 0);
    check("pt_stable_in_wait", 128'(pt_changes), 128'd0);
    check("sready_low_in_comp", 128'(sready_viol), 128'd0);

    // Consumer stall for 10 cycles, then next message with reloaded IV.
    msg = '{16'hBEEF, 16'h0042};
    run_msg("stall", 1'b0, 10);
    msg = '{16'h5};
    run_msg("after_stall", 1'b0, 0);

    // Reset while block 2 is in WAIT.
    send_block(16'h1, 1'b0);
    s_valid = 1'b0;
    t = 0;
    while (s_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    send_block(16'h2, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outputs", {125'h0, s_ready, digest_valid, busy}, 128'h4);
    check("midrst_chain", {core_prev_left, core_prev_right}, 128'h0);
    msg = '{16'h1234};
    run_msg("after_midrst", 1'b0, 0);

    // Core already done on the first WAIT cycle.
    stub_lat = 0;
    msg = '{16'h0777, 16'h8001};
    run_msg("lat0", 1'b0, 0);

    // Randomized messages, lengths, gaps and core latencies.
    for (int k = 0; k < 6; k++) begin
      int len = $urandom_range(1, 6);
      stub_lat = $urandom_range(0, 6);
      msg.delete();
      for (int j = 0; j < len; j++) msg.push_back(16'($urandom));
      run_msg("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    check("final_pt_stable", 128'(pt_changes), 128'd0);
    check("final_sready_low", 128'(sready_viol), 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hirose_present_stream_ctrl.md
Name: hirose_present_stream_ctrl

Overview:
Streaming sequencer for the hirose_present compression core.
- Accepts an arbitrary-length message as 16-bit blocks over a valid/ready handshake.
- Owns the 128-bit chaining state (left/right halves) and sequences the core once per block: reset pulse, wait, chain update.
- Optionally appends a block-count strengthening block.
- Presents the final 128-bit digest on a valid/ready output.
- Sits between a message source (UART/SD reader, CPU FIFO) and one hirose_present instance.

Parameters:
IV_LEFT, 64'h0, initial value of the left chaining half
IV_RIGHT, 64'h0, initial value of the right chaining half
C_CONST, 64'hFFFF_FFFF_FFFF_FFFF, Hirose constant c driven to the core
CNT_W, 16, block counter width (count wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_data  in  16  message block
s_valid  in  1  block valid
s_last  in  1  block is final block of message (qualified by s_valid)
s_ready  out  1  controller accepts block this cycle
digest  out  128  {H_left, H_right} final hash
digest_valid  out  1  digest available
digest_ready  in  1  consumer takes digest
core_rst  out  1  reset/start pulse to hirose_present
core_c  out  64  constant c (= C_CONST)
core_plaintext  out  16  block under compression, held stable during compression
core_prev_left  out  64  current H_left
core_prev_right  out  64  current H_right
core_end_hash  in  1  core finished; level, cleared by core_rst
core_hash_o  in  128  core result {left, right}
busy  out  1  high in every state except IDLE and DONE

Behaviour:
- Reset: state=IDLE, H_left=IV_LEFT, H_right=IV_RIGHT, block count=0, pt_reg=0, last_flag=0. Outputs s_ready=1, digest_valid=0, core_rst=0, busy=0. digest equals {IV_LEFT, IV_RIGHT}. A reset mid-operation abandons the message; no partial digest is produced.
- IDLE:
  - s_ready=1.
  - On s_valid: pt_reg<=s_data, last_flag<=s_last, count<=count+1 (wraps), go to START.
  - Zero-length messages are not supported; the first accepted block starts the message.
- START: core_rst=1 for exactly one cycle, s_ready=0, go to WAIT.
- WAIT:
  - core_end_hash is sampled only here; the first WAIT cycle may already see it high.
  - On core_end_hash=1 go to UPDATE. No timeout.
- UPDATE (1 cycle):
  - {H_left, H_right}<=core_hash_o.
  - If last_flag=0: go to ACCEPT.
  - Else if LEN_PAD enabled and the pad block is not yet done: pt_reg<=count[15:0] (zero-extended if CNT_W<16), set pad_done, go to START.
  - Else go to DONE.
- ACCEPT:
  - s_ready=1. On s_valid, same capture as IDLE (pt_reg, last_flag, count), go to START.
  - Gaps in s_valid are allowed indefinitely.
- s_ready is high only in IDLE and ACCEPT. A block is accepted exactly when s_valid && s_ready.
- core_plaintext=pt_reg, core_prev_left=H_left, core_prev_right=H_right, core_c=C_CONST. All are stable from START through UPDATE.
- DONE:
  - digest_valid=1, digest={H_left, H_right}, held stable until digest_ready.
  - On digest_valid && digest_ready: reload H from the IV parameters, count=0, clear pad_done, go to IDLE.
  - digest_ready while digest_valid=0 is ignored.
- Per-block latency: 1 accept cycle + 1 START cycle + core latency + 1 UPDATE cycle. The minimum digest_valid delay after the last block's UPDATE is 1 cycle.

Optional Feature:
Macro HIROSE_CTRL_LEN_PAD_EN.
- Defined: after the last message block, one extra compression runs on plaintext = message block count (mod 2^CNT_W, low 16 bits). The message is not accepted in the meantime.
- Undefined: pad states and logic are removed; DONE follows the last block's UPDATE directly.

Test Plan:
Bench core stub: end_hash rises 5 cycles after core_rst falls; hash_o = {prev_left ^ {48'h0, pt}, prev_right + {48'h0, pt}}. IV=0.
- Single block 16'h1234 with s_last -> digest {64'h1234, 64'h1234} without LEN_PAD; {64'h1235, 64'h1235} with LEN_PAD (pad block 1).
- Blocks 1, 2, 3 (last on 3) -> digest {64'h0, 64'h6} without LEN_PAD; {64'h3, 64'h9} with LEN_PAD. Exactly 3 (resp. 4) core_rst pulses, each 1 cycle wide.
- s_valid held high with 4 queued blocks -> s_ready low from START through UPDATE; core_plaintext constant during WAIT; no block lost or duplicated.
- digest_ready low for 10 cycles in DONE -> digest_valid and digest stable. Then pulse ready -> IDLE next cycle; next message {16'h5} yields {64'h5, 64'h5} (IV reloaded).
- rst asserted during WAIT of block 2 -> next cycle s_ready=1, digest_valid=0, core_prev_left/right=0. A new message 16'h1234 gives the same result as the first test.
- core_end_hash already high on the first WAIT cycle (stub latency 0) -> UPDATE the next cycle, digest correct.
